// File: rtl/booth_mac_ctrl.sv
// Booth multiplier sequencer + group accumulator: FIFO-buffered operand pairs, one summed result per in_last group.
// Define BOOTH_MAC_SAT_EN for saturating accumulation with a sticky out_sat flag (default: wrap-around).
module booth_mac_ctrl #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [15:0]      mul_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             out_sat,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, EMIT} state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] a;
        logic [7:0] b;
    } entry_t;

    state_t      state;
    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;
    logic        cur_last;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == IDLE) && !empty;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign busy     = (state != IDLE) || !empty;

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{last: in_last, a: in_a, b: in_b};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    logic [ACC_W-1:0] prod_ext, acc_next;
    logic             sat_hit;
`ifdef BOOTH_MAC_SAT_EN
    logic signed [ACC_W:0] sum_w;
`endif

    // NOTE: every output of this block is given a default first, so no latch can form.
    always_comb begin
        prod_ext = ACC_W'($signed(mul_m));
        sat_hit  = 1'b0;
`ifdef BOOTH_MAC_SAT_EN
        sum_w    = (ACC_W+1)'($signed(out_acc)) + (ACC_W+1)'($signed(prod_ext));
        acc_next = sum_w[ACC_W-1:0];
        if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
            sat_hit  = 1'b1;
            acc_next = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        acc_next = out_acc + prod_ext;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            cur_last  <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        mul_a     <= head.a;
                        mul_b     <= head.b;
                        cur_last  <= head.last;
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Leaving ISSUE on the first done cycle guarantees one capture per pair.
                    if (mul_done) begin
                        out_acc   <= acc_next;
                        if (out_count != 8'hFF) out_count <= out_count + 8'd1;
                        out_sat   <= out_sat | sat_hit;
                        mul_start <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!mul_done) begin
                        if (cur_last) begin
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_acc   <= '0;
                        out_count <= '0;
                        out_sat   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Bench for booth_mac_ctrl: 24-bit and 16-bit instances, each driving a behavioural multiplier stub.
module tb_booth_mac_ctrl;

    localparam int STUB_LAT = 4;

    typedef struct {
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      in_valid, in_ready, in_last, mul_start, mul_done;
    logic [1:0]      out_valid, out_ready, out_sat, busy;
    logic [1:0][7:0] in_a, in_b, mul_a, mul_b, out_count;
    logic [1:0][15:0] mul_m;
    logic [23:0]     acc0;
    logic [15:0]     acc16;
    logic [23:0]     acc1;
    int              done_hold = 1;

    assign acc1 = {{8{acc16[15]}}, acc16};

    always #5 clk = ~clk;

    booth_mac_ctrl #(.DEPTH(4), .ACC_W(24)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_start(mul_start[0]), .mul_done(mul_done[0]), .mul_m(mul_m[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_acc(acc0), .out_count(out_count[0]),
        .out_sat(out_sat[0]), .busy(busy[0])
    );

    booth_mac_ctrl #(.DEPTH(4), .ACC_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_start(mul_start[1]), .mul_done(mul_done[1]), .mul_m(mul_m[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_acc(acc16), .out_count(out_count[1]),
        .out_sat(out_sat[1]), .busy(busy[1])
    );

    // Multiplier stub: latches operands on start, raises done for done_hold cycles, then waits for start low.
    for (genvar g = 0; g < 2; g++) begin : g_stub
        logic [1:0]  st;
        int          cnt;
        logic        done_r;
        logic [15:0] m_r, prod;
        assign mul_done[g] = done_r;
        assign mul_m[g]    = m_r;
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st <= 2'd0; cnt <= 0; done_r <= 1'b0; m_r <= '0; prod <= '0;
            end else begin
                case (st)
                    2'd0: if (mul_start[g]) begin
                        prod <= $signed({{8{mul_a[g][7]}}, mul_a[g]}) * $signed({{8{mul_b[g][7]}}, mul_b[g]});
                        cnt  <= STUB_LAT;
                        st   <= 2'd1;
                    end
                    2'd1: if (cnt == 0) begin
                        done_r <= 1'b1; m_r <= prod; cnt <= done_hold - 1; st <= 2'd2;
                    end else cnt <= cnt - 1;
                    2'd2: if (cnt == 0) begin
                        done_r <= 1'b0; st <= 2'd3;
                    end else cnt <= cnt - 1;
                    default: if (!mul_start[g]) st <= 2'd0;
                endcase
            end
        end
    end

    int     n_pass = 0, n_total = 0;
    exp_t   exp_q0[$], exp_q1[$];
    longint m_acc[2];
    int     m_cnt[2];
    logic   m_sat[2];
    logic [23:0] last_acc[2];
    logic [7:0]  last_cnt[2];
    logic        last_sat[2];
    int     rises0 = 0, viol = 0, hs0 = 0;
    logic   prev_start = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear(input int g);
        m_acc[g] = 0; m_cnt[g] = 0; m_sat[g] = 1'b0;
    endtask

    // Reference accumulator: exact product, then saturate or wrap at the instance's width.
    task automatic model_pair(input int g, input logic signed [7:0] a, input logic signed [7:0] b, input logic last);
        int     w = (g == 0) ? 24 : 16;
        longint sum = m_acc[g] + longint'(a) * longint'(b);
        exp_t   e;
`ifdef BOOTH_MAC_SAT_EN
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        if (sum > hi) begin sum = hi; m_sat[g] = 1'b1; end
        if (sum < lo) begin sum = lo; m_sat[g] = 1'b1; end
`else
        sum = (sum <<< (64 - w)) >>> (64 - w);
`endif
        m_acc[g] = sum;
        if (m_cnt[g] < 255) m_cnt[g]++;
        if (last) begin
            e.acc = sum[23:0]; e.cnt = 8'(m_cnt[g]); e.sat = m_sat[g];
            if (g == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            model_clear(g);
        end
    endtask

    task automatic sb_pop(input int g, input logic [23:0] acc, input logic [7:0] cnt, input logic sat);
        exp_t e;
        if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
            check($sformatf("g%0d_unexpected_result", g), 32'd1, 32'd0);
        end else begin
            e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("g%0d_acc", g), 32'(acc), 32'(e.acc));
            check($sformatf("g%0d_count", g), 32'(cnt), 32'(e.cnt));
            check($sformatf("g%0d_sat", g), 32'(sat), 32'(e.sat));
        end
    endtask

    // Results are popped on the negedge before the accepting posedge.
    always @(negedge clk) begin
        prev_start <= mul_start[0];
        if (mul_start[0] && !prev_start) begin
            rises0 <= rises0 + 1;
            if (mul_done[0]) viol <= viol + 1;
        end
        if (reset_n && out_valid[0] && out_ready[0]) begin
            hs0 <= hs0 + 1;
            last_acc[0] <= acc0; last_cnt[0] <= out_count[0]; last_sat[0] <= out_sat[0];
            sb_pop(0, acc0, out_count[0], out_sat[0]);
        end
        if (reset_n && out_valid[1] && out_ready[1]) begin
            last_acc[1] <= acc1; last_cnt[1] <= out_count[1]; last_sat[1] <= out_sat[1];
            sb_pop(1, acc1, out_count[1], out_sat[1]);
        end
    end

    task automatic send(input int g, input logic signed [7:0] a, input logic signed [7:0] b, input logic last);
        int t = 0;
        in_valid[g] = 1'b1; in_a[g] = a; in_b[g] = b; in_last[g] = last;
        @(negedge clk);
        while (!in_ready[g] && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) check($sformatf("g%0d_send_timeout", g), 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        model_pair(g, a, b, last);
    endtask

    task automatic wait_drain(input int g);
        int t = 0;
        while (((g == 0) ? exp_q0.size() : exp_q1.size()) > 0 && t < 2000) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("g%0d_drain", g), 32'((g == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
    endtask

    logic signed [7:0] pa[6] = '{8'sd5, -8'sd6, 8'sd100, -8'sd100, -8'sd128, 8'sd33};
    logic signed [7:0] pb[6] = '{-8'sd7, 8'sd8, 8'sd3, -8'sd1, -8'sd128, 8'sd2};

    initial begin
        int base, taken, t;
        logic start_seen, acc_stable, took;
        logic [23:0] acc_hold;

        reset_n = 1'b0; in_valid = '0; in_a = '0; in_b = '0; in_last = '0; out_ready = 2'b11;
        model_clear(0); model_clear(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("rst_mul_start", 32'(mul_start[0]), 32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out_acc", 32'(acc0), 32'd0);
        check("rst_out_count", 32'(out_count[0]), 32'd0);
        check("rst_out_sat", 32'(out_sat[0]), 32'd0);
        check("rst_mul_a", 32'(mul_a[0]), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy[0]), 32'd0);

        // Single pair: push lands at the next edge, start rises one edge later.
        base = rises0;
        in_valid[0] = 1'b1; in_a[0] = 8'd3; in_b[0] = 8'hFC; in_last[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        model_pair(0, 8'sd3, -8'sd4, 1'b1);
        check("t1_start_after_push", 32'(mul_start[0]), 32'd0);
        check("t1_busy", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        check("t1_start_next", 32'(mul_start[0]), 32'd1);
        wait_drain(0);
        check("t1_start_pulses", 32'(rises0 - base), 32'd1);
        check("t1_acc_const", 32'(last_acc[0]), 32'hFFFFF4);
        check("t1_count_const", 32'(last_cnt[0]), 32'd1);

        // Four-pair group with extreme operands.
        base = hs0;
        send(0, 8'sd127, 8'sd127, 1'b0);
        send(0, 8'sd127, 8'sd127, 1'b0);
        send(0, -8'sd128, -8'sd128, 1'b0);
        send(0, -8'sd128, 8'sd127, 1'b1);
        wait_drain(0);
        check("t2_one_result", 32'(hs0 - base), 32'd1);
        check("t2_acc_const", 32'(last_acc[0]), 32'd32386);
        check("t2_count_const", 32'(last_cnt[0]), 32'd4);
        check("t2_valid_low", 32'(out_valid[0]), 32'd0);

        // Back-pressure: result held in EMIT while six more pairs are offered.
        out_ready[0] = 1'b0;
        send(0, 8'sd1, 8'sd1, 1'b1);
        t = 0;
        while (!out_valid[0] && t < 200) begin @(posedge clk); t++; end
        #1;
        check("t3_result_valid", 32'(out_valid[0]), 32'd1);
        acc_hold = acc0; taken = 0; start_seen = 1'b0; acc_stable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid[0] = (taken < 6);
            if (taken < 6) begin in_a[0] = pa[taken]; in_b[0] = pb[taken]; in_last[0] = 1'b1; end
            @(negedge clk);
            if (acc0 !== acc_hold) acc_stable = 1'b0;
            if (mul_start[0]) start_seen = 1'b1;
            took = in_valid[0] && in_ready[0];
            @(posedge clk); #1;
            if (took) begin model_pair(0, pa[taken], pb[taken], 1'b1); taken++; end
        end
        in_valid[0] = 1'b0;
        check("t3_accepted", 32'(taken), 32'd4);
        check("t3_in_ready_low", 32'(in_ready[0]), 32'd0);
        check("t3_no_start", 32'(start_seen), 32'd0);
        check("t3_acc_stable", 32'(acc_stable), 32'd1);
        out_ready[0] = 1'b1;
        for (int k = 4; k < 6; k++) send(0, pa[k], pb[k], 1'b1);
        wait_drain(0);

        // Long done pulse: one capture, no reissue until done falls.
        done_hold = 5;
        base = viol;
        send(0, 8'sd10, -8'sd3, 1'b0);
        send(0, 8'sd4, 8'sd5, 1'b1);
        wait_drain(0);
        check("t4_no_start_during_done", 32'(viol - base), 32'd0);
        check("t4_acc_const", 32'(last_acc[0]), 32'hFFFFF6);
        check("t4_count_const", 32'(last_cnt[0]), 32'd2);
        done_hold = 1;

        // Reset in ISSUE of the second pair of a group.
        base = rises0;
        send(0, 8'sd9, 8'sd9, 1'b0);
        send(0, 8'sd7, 8'sd7, 1'b1);
        t = 0;
        while (rises0 < base + 2 && t < 500) begin @(posedge clk); t++; end
        check("t5_second_issue", 32'(rises0 - base), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_start", 32'(mul_start[0]), 32'd0);
        check("t5_rst_valid", 32'(out_valid[0]), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("t5_rst_acc", 32'(acc0), 32'd0);
        exp_q0.delete(); exp_q1.delete();
        model_clear(0); model_clear(1);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        send(0, 8'sd2, 8'sd5, 1'b1);
        wait_drain(0);
        check("t5_acc_const", 32'(last_acc[0]), 32'd10);
        check("t5_count_const", 32'(last_cnt[0]), 32'd1);

        // 16-bit accumulator overflow.
        send(1, 8'sd127, 8'sd127, 1'b0);
        send(1, 8'sd127, 8'sd127, 1'b0);
        send(1, 8'sd127, 8'sd127, 1'b1);
        wait_drain(1);
`ifdef BOOTH_MAC_SAT_EN
        check("t6_acc_const", 32'(last_acc[1]), 32'h007FFF);
        check("t6_sat_const", 32'(last_sat[1]), 32'd1);
`else
        check("t6_acc_const", 32'(last_acc[1]), 32'hFFBD03);
        check("t6_sat_const", 32'(last_sat[1]), 32'd0);
`endif
        check("t6_count_const", 32'(last_cnt[1]), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/booth_mac_ctrl.md
Name: booth_mac_ctrl

Overview:
Sequencer and accumulator wrapped around the 8-bit sequential Booth multiplier. It buffers signed operand pairs from an upstream valid/ready stream in a small FIFO and drives the multiplier's A/B/start inputs. It consumes each 16-bit product on the multiplier's done handshake, accumulates products into a wide signed accumulator, and emits one accumulated result per group, with the group delimited by in_last.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, >= 2
ACC_W, 24, accumulator / out_acc width; >= 16

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept a pair
in_a  in  8  signed multiplicand
in_b  in  8  signed multiplier
in_last  in  1  pair closes current accumulation group
mul_a  out  8  to multiplier A
mul_b  out  8  to multiplier B
mul_start  out  1  to multiplier start
mul_done  in  1  from multiplier done
mul_m  in  16  from multiplier M, signed product
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_acc  out  ACC_W  signed group sum
out_count  out  8  products in group, saturates at 255
out_sat  out  1  group saturated (see Optional Feature)
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (async, reset_n low):
  - FIFO empties; FSM goes to IDLE.
  - mul_a, mul_b, mul_start, out_valid, out_acc, out_count, out_sat all reset to 0.
  - in_ready resets to 1.
  - The multiplier must be reset in the same event; reset mid-operation discards the in-flight pair and the partial sum.
- FIFO:
  - Entries are {last, a, b}. in_ready = !full.
  - Push on in_valid && in_ready.
  - Pop only in IDLE.
  - Push and pop in the same cycle are both honoured when the FIFO is not full. There is no bypass; data is visible to IDLE one cycle after push.
- FSM states: IDLE, ISSUE, RELEASE, EMIT.
  - IDLE: if the FIFO is non-empty, pop the head and register a/b into mul_a/mul_b and last into cur_last. Set mul_start = 1 and go to ISSUE. mul_a and mul_b then hold until the next pop.
  - ISSUE: hold mul_start = 1. On mul_done = 1:
    - acc <= acc + sign-extend(mul_m) to ACC_W
    - out_count increments, saturating at 255
    - mul_start <= 0; go to RELEASE
    - A product is captured exactly once per pair, however long mul_done stays high.
  - RELEASE: mul_start = 0. Wait for mul_done = 0, then go to EMIT if cur_last, else IDLE.
  - EMIT: out_valid = 1; out_acc, out_count and out_sat held stable. On out_ready, clear acc/count/sat and go to IDLE. No new pair is issued while in EMIT; the FIFO still accepts pushes.
- Latency:
  - Push in cycle N gives mul_start high from cycle N+2.
  - One pair costs the multiplier's latency plus 2 controller cycles (ISSUE to RELEASE, RELEASE to IDLE).
- Arithmetic: two's complement. Without the optional feature, the accumulator wraps modulo 2^ACC_W.
- out_acc outputs acc continuously; it is valid only while out_valid is high.

Optional Feature:
- Macro: BOOTH_MAC_SAT_EN.
- Defined:
  - Accumulation saturates to the signed max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)).
  - Any saturation in a group sets sticky out_sat, reported with that group's result and cleared on acceptance.
- Undefined:
  - Wrap-around addition; out_sat tied to 0.

Test Plan:
- Single pair (3, 0xFC = -4), last=1 -> mul_start pulses once; out_acc = 0xFFFFF4 (-12), out_count = 1, out_sat = 0.
- Group (127,127), (127,127), (-128,-128), (-128,127, last) -> out_acc = 32386, out_count = 4, exactly one out_valid.
- out_ready held low 30 cycles after a result while 6 more pairs are offered -> in_ready drops after 4 accepted; mul_start stays 0; out_acc stable; release drains in order.
- Multiplier stub holds mul_done high 5 cycles -> product added once; RELEASE waits for mul_done low before the next issue.
- reset_n low during ISSUE -> mul_start, out_valid drop immediately; in_ready = 1; post-reset pair (2,5,last) gives out_acc = 10, out_count = 1.
- ACC_W=16, three (127,127) pairs with last on the third -> without macro out_acc = -17149; with BOOTH_MAC_SAT_EN out_acc = 32767, out_sat = 1.
